// File: rtl/instruction_fetch.sv
// Fetch stage: issues PC-driven instruction memory reads, buffers returned words in a small FIFO
// and steers the PC step. Optional FETCH_BYPASS_EN forwards an ack straight to an empty, ready decoder.
module instruction_fetch #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_step,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_offset,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DISCARD
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] w_mem_addr_next;

    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;

    logic w_fifo_empty;
    logic w_fifo_full;
    logic w_fetch_done;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == CNT_W'(DEPTH));
    assign w_fetch_done = (r_state == S_REQ) && mem_ack && !redirect;

`ifdef FETCH_BYPASS_EN
    // An empty FIFO with a ready decoder lets the returning word skip storage entirely.
    assign w_bypass = w_fetch_done && w_fifo_empty && instr_ready;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_fetch_done && !w_bypass;
    assign w_pop  = !w_fifo_empty && instr_ready;

    assign mem_req     = (r_state != S_IDLE);
    assign mem_addr    = r_mem_addr;
    assign instr_valid = !w_fifo_empty || w_bypass;

    always_comb begin
        instr_data = '0;
        instr_addr = '0;
        if (w_bypass) begin
            instr_data = mem_rdata;
            instr_addr = r_mem_addr;
        end else if (!w_fifo_empty) begin
            instr_data = r_fifo_data[r_rd_ptr];
            instr_addr = r_fifo_addr[r_rd_ptr];
        end
    end

    always_comb begin
        pc_step = '0;
        if (redirect) begin
            pc_step = redirect_offset;
        end else if (w_fetch_done) begin
            pc_step = ADDR_W'(1);
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_mem_addr_next = r_mem_addr;
        case (r_state)
            S_IDLE: begin
                if (!redirect && !w_fifo_full) begin
                    w_state_next    = S_REQ;
                    w_mem_addr_next = pc;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    // An ack in the redirect cycle is simply dropped; otherwise wait it out.
                    w_state_next = mem_ack ? S_IDLE : S_DISCARD;
                end else if (mem_ack) begin
                    if (w_count_next != CNT_W'(DEPTH)) begin
                        w_mem_addr_next = r_mem_addr + ADDR_W'(1);
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_DISCARD: begin
                if (mem_ack) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_mem_addr <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_mem_addr <= w_mem_addr_next;
            if (redirect) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                r_count <= w_count_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= mem_rdata;
            r_fifo_addr[r_wr_ptr] <= r_mem_addr;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed table plus corner sequences, then random traffic
// against a request-level scoreboard (expected words queue, PC register and memory model).
`timescale 1ns/1ps
module tb_instruction_fetch;

    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] pc = '0;
    logic [AW-1:0] pc_step;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_offset = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_addr;

    always #5 clk = ~clk;

    instruction_fetch #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .pc_step         (pc_step),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .redirect        (redirect),
        .redirect_offset (redirect_offset),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_data      (instr_data),
        .instr_addr      (instr_addr)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } word_t;

    typedef struct {
        logic [AW-1:0] start;
        int            lat;
        logic [AW-1:0] e0;
        logic [AW-1:0] e1;
        logic [AW-1:0] e2;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Scoreboard / environment state
    word_t         q[$];
    logic [AW-1:0] consumed[$];
    logic [AW-1:0] pc_next = '0;
    bit            outstanding = 0;
    bit            dropped = 0;
    int            wait_cnt = 0;
    logic [AW-1:0] req_addr = '0;
    logic [AW-1:0] last_req_addr = '0;
    int            n_ack = 0;
    int            n_req = 0;

    // Stimulus knobs
    int            lat = 1;
    int            ready_mode = 0;
    bit            rd_rand = 0;
    int            rd_arm = 0;
    logic [AW-1:0] rd_off = '0;
    bit            use_beef = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input logic [AW-1:0] start);
        @(posedge clk);
        #2;
        reset = 1'b0;
        mem_ack = 1'b0;
        redirect = 1'b0;
        redirect_offset = '0;
        instr_ready = 1'b0;
        mem_rdata = '0;
        pc = start;
        pc_next = start;
        q.delete();
        consumed.delete();
        outstanding = 0;
        dropped = 0;
        rd_arm = 0;
        n_ack = 0;
        n_req = 0;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr_data", instr_data, 0);
        chk("rst_instr_addr", instr_addr, 0);
        chk("rst_pc_step", pc_step, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic cycle();
        bit            new_req;
        bit            delivered;
        bit            byp_word;
        bit            exp_valid;
        bit            fire;
        logic [AW-1:0] exp_step;
        word_t         head;
        @(posedge clk);
        #1;
        pc = pc_next;
        if (outstanding) chk("req_held", mem_req, 1);
        new_req = mem_req && !outstanding;
        if (new_req) begin
            chk("req_addr_eq_pc", mem_addr, pc);
            chk("req_with_space", q.size() < DEPTH, 1);
            outstanding = 1;
            dropped = 0;
            req_addr = mem_addr;
            last_req_addr = mem_addr;
            n_req++;
            wait_cnt = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
        end else if (mem_req) begin
            chk("addr_stable", mem_addr, req_addr);
        end
        mem_ack = 1'b0;
        mem_rdata = DW'($urandom);
        if (outstanding) begin
            if (wait_cnt == 0) begin
                mem_ack = 1'b1;
                if (use_beef) mem_rdata = 16'hBEEF;
            end else begin
                wait_cnt--;
            end
        end
        redirect = 1'b0;
        redirect_offset = AW'($urandom);
        fire = (rd_arm == 1) || (rd_arm == 2 && outstanding && !mem_ack) ||
               (rd_arm == 3 && mem_ack && !dropped);
        if (fire) begin
            redirect = 1'b1;
            redirect_offset = rd_off;
            rd_arm = 0;
        end else if (rd_rand && $urandom_range(0, 99) < 5) begin
            redirect = 1'b1;
        end
        instr_ready = (ready_mode == 2) ? ($urandom_range(0, 99) < 70) : (ready_mode == 1);
        #4;
        delivered = mem_ack && !dropped && !redirect;
        exp_step = redirect ? redirect_offset : (delivered ? AW'(1) : AW'(0));
        chk("pc_step", pc_step, exp_step);
        if (q.size() == DEPTH) chk("idle_when_full", mem_req, 0);
        byp_word = BYP && delivered && (q.size() == 0) && instr_ready;
        exp_valid = (q.size() > 0) || byp_word;
        chk("instr_valid", instr_valid, exp_valid);
        if (exp_valid && instr_ready) begin
            head = (q.size() > 0) ? q[0] : {req_addr, mem_rdata};
            chk("instr_addr", instr_addr, head.addr);
            chk("instr_data", instr_data, head.data);
            consumed.push_back(instr_addr);
            $display("instr addr=%03h data=%04h", instr_addr, instr_data);
        end
        if (delivered && !byp_word) q.push_back({req_addr, mem_rdata});
        if (exp_valid && instr_ready && !byp_word) void'(q.pop_front());
        if (redirect) q.delete();
        if (outstanding && redirect) dropped = 1;
        if (mem_ack) begin
            outstanding = 0;
            dropped = 0;
            n_ack++;
        end
        pc_next = pc + exp_step;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[3];
        int   n_before;
        vecs[0] = '{12'h000, 2, 12'h000, 12'h001, 12'h002};
        vecs[1] = '{12'hFFF, 0, 12'hFFF, 12'h000, 12'h001};
        vecs[2] = '{12'h7FE, 1, 12'h7FE, 12'h7FF, 12'h800};

        // Sequential fetch after reset release, including address wrap
        for (int i = 0; i < 3; i++) begin
            lat = vecs[i].lat;
            ready_mode = 1;
            rd_rand = 0;
            use_beef = 0;
            do_reset(vecs[i].start);
            cycle();
            chk("req_after_release", mem_req, 1);
            chk("first_req_addr", mem_addr, vecs[i].start);
            for (int c = 0; c < 40 && consumed.size() < 3; c++) cycle();
            chk("seq_got_three", consumed.size() >= 3, 1);
            if (consumed.size() >= 3) begin
                chk("seq_addr0", consumed[0], vecs[i].e0);
                chk("seq_addr1", consumed[1], vecs[i].e1);
                chk("seq_addr2", consumed[2], vecs[i].e2);
            end
        end

        // Stalled decoder fills the FIFO, one pop yields one refill
        lat = 0;
        ready_mode = 0;
        do_reset(12'h000);
        for (int c = 0; c < 12; c++) cycle();
        chk("acks_when_stalled", n_ack, 4);
        chk("req_low_when_full", mem_req, 0);
        n_before = n_req;
        ready_mode = 1;
        cycle();
        ready_mode = 0;
        for (int c = 0; c < 6; c++) cycle();
        chk("one_refill_req", n_req - n_before, 1);
        chk("refill_addr", last_req_addr, 12'h004);

        // Redirect while a request waits for its ack
        lat = 0;
        ready_mode = 0;
        do_reset(12'h100);
        cycle();
        cycle();
        lat = 3;
        rd_arm = 2;
        rd_off = 12'h010;
        cycle();
        chk("redir_step", pc_step, 12'h010);
        cycle();
        chk("redir_flushed", instr_valid, 0);
        n_before = n_req;
        for (int c = 0; c < 12 && n_req == n_before; c++) cycle();
        chk("redir_new_addr", last_req_addr, 12'h112);

        // Redirect coinciding with the ack
        lat = 1;
        do_reset(12'h050);
        cycle();
        rd_arm = 3;
        rd_off = 12'hFFE;
        cycle();
        chk("redir_ack_step", pc_step, 12'hFFE);
        cycle();
        chk("redir_ack_no_push", instr_valid, 0);
        n_before = n_req;
        for (int c = 0; c < 12 && n_req == n_before; c++) cycle();
        chk("redir_ack_addr", last_req_addr, 12'h04E);

        // First word into an empty FIFO with a ready decoder
        lat = 1;
        ready_mode = 1;
        use_beef = 1;
        do_reset(12'h200);
        cycle();
        cycle();
        chk("byp_ack_valid", instr_valid, BYP);
        if (instr_valid) chk("byp_ack_data", instr_data, 16'hBEEF);
        use_beef = 0;
        cycle();
        chk("byp_next_valid", instr_valid, !BYP);
        if (instr_valid) chk("byp_next_data", instr_data, 16'hBEEF);

        // Random traffic against the scoreboard
        lat = -1;
        ready_mode = 2;
        rd_rand = 1;
        do_reset(AW'($urandom));
        for (int c = 0; c < 600; c++) cycle();

        // Asynchronous reset in the middle of a request
        rd_rand = 0;
        ready_mode = 1;
        lat = 3;
        for (int c = 0; c < 20 && !mem_req; c++) cycle();
        chk("req_before_async_rst", mem_req, 1);
        do_reset(12'h000);
        lat = 0;
        for (int c = 0; c < 5; c++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
